bcd_decoder: RTL and testbench

- Converts an N-bit unsigned binary value from board switches into four decimal digits: units, tens, hundreds, thousands.
- Drives four active-low 7-segment displays.
- Uses a sequential shift-add-3 (double-dabble) engine and registered segment outputs.
- Sits between the switch input and the board display pins.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_decoder_if.sv | 13 +
 rtl/seg7_encoder.sv | 26 ++
 rtl/bcd_decoder.sv | 110 +++++++++++
 tb/tb_bcd_decoder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and nibble-adjust helper for the BCD display decoder.
package bcd_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int BCD_W = 16;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_decoder_if.sv
// Switch-input and display-output bundle of the BCD decoder; slave side is the decoder.
interface bcd_decoder_if #(parameter int N = 10);

  logic [N-1:0] bcd_in_sw;
  logic [6:0]   Disp_un;
  logic [6:0]   Disp_dec;
  logic [6:0]   Disp_cent;
  logic [6:0]   Disp_mil;

  modport master (output bcd_in_sw, input Disp_un, Disp_dec, Disp_cent, Disp_mil);
  modport slave  (input bcd_in_sw, output Disp_un, Disp_dec, Disp_cent, Disp_mil);

endinterface

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment encoder; 10-15 show blank.
module seg7_encoder
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_decoder.sv
// Switch value to four active-low 7-segment digits via a sequential double-dabble engine.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module bcd_decoder
  import bcd_pkg::*;
#(
  parameter int N = 10
)(
  input  logic         clk,
  input  logic         rst,
  bcd_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int SR_W  = BCD_W + N;

  generate
    if (N < 4 || N > 13) begin : gNRangeCheck
      $error("bcd_decoder: N must be within 4..13");
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] UPPER_RST = SEG_BLANK;
`else
  localparam logic [6:0] UPPER_RST = SEG_0;
`endif

  state_t           state_q;
  logic [N-1:0]     lastVal_q;
  logic [SR_W-1:0]  shiftReg_q;
  logic [SR_W-1:0]  shiftReg_d;
  logic [SR_W-1:0]  adjusted;
  logic [CNT_W-1:0] iterCnt_q;
  logic [6:0]       dispUn_q, dispDec_q, dispCent_q, dispMil_q;
  logic [6:0]       dispDec_d, dispCent_d, dispMil_d;
  logic [6:0]       segUn, segDec, segCent, segMil;
  logic [3:0]       nibDec, nibCent, nibMil;

  always_comb begin
    adjusted = shiftReg_q;
    for (int i = 0; i < 4; i++) begin
      adjusted[N + 4*i +: 4] = add3(shiftReg_q[N + 4*i +: 4]);
    end
    shiftReg_d = adjusted << 1;
  end

  assign nibDec  = shiftReg_q[N + 4  +: 4];
  assign nibCent = shiftReg_q[N + 8  +: 4];
  assign nibMil  = shiftReg_q[N + 12 +: 4];

  seg7_encoder uEncUn   (.digit_i(shiftReg_q[N +: 4]), .seg_o(segUn));
  seg7_encoder uEncDec  (.digit_i(nibDec),             .seg_o(segDec));
  seg7_encoder uEncCent (.digit_i(nibCent),            .seg_o(segCent));
  seg7_encoder uEncMil  (.digit_i(nibMil),             .seg_o(segMil));

  always_comb begin
    dispMil_d  = segMil;
    dispCent_d = segCent;
    dispDec_d  = segDec;
`ifdef LEADING_ZERO_BLANK_EN
    if (nibMil == 4'd0)                                        dispMil_d  = SEG_BLANK;
    if (nibMil == 4'd0 && nibCent == 4'd0)                     dispCent_d = SEG_BLANK;
    if (nibMil == 4'd0 && nibCent == 4'd0 && nibDec == 4'd0)   dispDec_d  = SEG_BLANK;
`endif
  end

  // Outputs only change in LOAD, so a conversion in flight is never visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lastVal_q  <= '0;
      iterCnt_q  <= '0;
      shiftReg_q <= '0;
      dispUn_q   <= SEG_0;
      dispDec_q  <= UPPER_RST;
      dispCent_q <= UPPER_RST;
      dispMil_q  <= UPPER_RST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.bcd_in_sw != lastVal_q) begin
            lastVal_q  <= bus.bcd_in_sw;
            shiftReg_q <= {{BCD_W{1'b0}}, bus.bcd_in_sw};
            iterCnt_q  <= '0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          shiftReg_q <= shiftReg_d;
          iterCnt_q  <= iterCnt_q + CNT_W'(1);
          if (iterCnt_q == CNT_W'(N - 1)) state_q <= LOAD;
        end
        LOAD: begin
          dispUn_q   <= segUn;
          dispDec_q  <= dispDec_d;
          dispCent_q <= dispCent_d;
          dispMil_q  <= dispMil_d;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Disp_un   = dispUn_q;
  assign bus.Disp_dec  = dispDec_q;
  assign bus.Disp_cent = dispCent_q;
  assign bus.Disp_mil  = dispMil_q;

endmodule

// File: tb/tb_bcd_decoder.sv
// Self-checking bench for bcd_decoder: vector table, latency/abort sequences and random values.
module tb_bcd_decoder;

  localparam int N = 10;

  typedef struct {
    int          value;
    logic [27:0] expSegs;
  } vec_t;

  typedef struct {
    logic [27:0] segs;
  } expect_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  expect_t scoreboard[$];
  vec_t    vectors[9];

  bcd_decoder_if #(.N(N)) bus ();

  bcd_decoder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference display {mil,cent,dec,un} computed arithmetically from the value
  function automatic logic [27:0] expectedSegs(input int value);
    int m, c, d, u;
    logic [6:0] sm, sc, sd;
    m = value / 1000;
    c = (value / 100) % 10;
    d = (value / 10) % 10;
    u = value % 10;
    sm = segOf(m);
    sc = segOf(c);
    sd = segOf(d);
`ifdef LEADING_ZERO_BLANK_EN
    if (m == 0)                   sm = 7'h7F;
    if (m == 0 && c == 0)         sc = 7'h7F;
    if (m == 0 && c == 0 && d == 0) sd = 7'h7F;
`endif
    return {sm, sc, sd, segOf(u)};
  endfunction

  function automatic logic [27:0] resetSegs();
`ifdef LEADING_ZERO_BLANK_EN
    return {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    return {7'h40, 7'h40, 7'h40, 7'h40};
`endif
  endfunction

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExpect(input logic [27:0] segs);
    expect_t e;
    e.segs = segs;
    scoreboard.push_back(e);
  endtask

  task automatic applyStimulus(input int value, input logic [27:0] segs);
    bus.bcd_in_sw = N'(value);
    pushExpect(segs);
  endtask

  task automatic checkOutput(input string name);
    expect_t e;
    logic [27:0] actual;
    actual = {bus.Disp_mil, bus.Disp_cent, bus.Disp_dec, bus.Disp_un};
    checks++;
    if (scoreboard.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", name, actual);
    end else begin
      e = scoreboard.pop_front();
      if (actual !== e.segs) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", name, actual, e.segs);
      end
    end
  endtask

  initial begin
    logic [6:0] topDigit;
    int value;
    checks = 0;
    errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    topDigit = 7'h7F;
`else
    topDigit = 7'h40;
`endif
    vectors[0] = '{509,  {topDigit, 7'h12, 7'h40, 7'h10}};
    vectors[1] = '{0,    expectedSegs(0)};
    vectors[2] = '{1,    expectedSegs(1)};
    vectors[3] = '{10,   expectedSegs(10)};
    vectors[4] = '{99,   expectedSegs(99)};
    vectors[5] = '{100,  expectedSegs(100)};
    vectors[6] = '{1000, expectedSegs(1000)};
    vectors[7] = '{1010, expectedSegs(1010)};
    vectors[8] = '{512,  expectedSegs(512)};

    rst = 1'b1;
    bus.bcd_in_sw = '0;
    waitClocks(3);
    pushExpect(resetSegs());
    checkOutput("reset");
    rst = 1'b0;
    waitClocks(1);

    // Exact latency: old display through edge k+N, new display at edge k+N+1
    pushExpect(resetSegs());
    applyStimulus(1023, {7'h79, 7'h40, 7'h24, 7'h30});
    waitClocks(N + 1);
    checkOutput("hold_1023");
    waitClocks(1);
    checkOutput("max_1023");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vectors[i].value, vectors[i].expSegs);
      waitClocks(N + 2);
      checkOutput($sformatf("vec_%0d", vectors[i].value));
    end

    // Change during CONV: first result shown, then the newer value
    applyStimulus(258, expectedSegs(258));
    pushExpect(expectedSegs(7));
    waitClocks(4);
    bus.bcd_in_sw = N'(7);
    waitClocks(N + 2 - 4);
    checkOutput("midconv_258");
    waitClocks(N + 2);
    checkOutput("midconv_7");

    // Asynchronous reset mid-conversion, then restart
    applyStimulus(999, resetSegs());
    pushExpect(expectedSegs(999));
    waitClocks(5);
    #3 rst = 1'b1;
    #1;
    checkOutput("abort_reset");
    waitClocks(2);
    rst = 1'b0;
    waitClocks(N + 2);
    checkOutput("restart_999");

    for (int i = 0; i < 10; i++) begin
      value = int'($urandom_range(0, 1023));
      applyStimulus(value, expectedSegs(value));
      waitClocks(2 * (N + 2));
      checkOutput($sformatf("rand_%0d", value));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
